// File: rtl/ttd_conv_ctrl.sv
// ---------------------------------------------------------------------------
// ttd_conv_ctrl
// Conversion sequencer for the time-to-digital converter front end.
// Each conversion discharges the ramp capacitor, releases it, runs a
// down-counting time base, captures the count on the first synchronised
// comparator rising edge (or times out), offset-corrects and saturates it
// to 8 bits, and presents the result on a valid/ready interface.
//
// Optional feature macro: TTD_AVG_EN
//   When defined, 2^AVG_LOG2 raw captures are summed and their mean is
//   converted and presented once per group.
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-low reset
//   i_start     one-cycle conversion request (only honoured in IDLE)
//   i_cont      continuous mode, sampled at the output handshake
//   i_cmp_in    comparator output, asynchronous to i_clk
//   o_rst_cap   capacitor discharge (1 = discharge)
//   o_busy      high whenever the sequencer is not IDLE
//   o_data_out  corrected 8-bit result
//   o_valid     o_data_out valid
//   i_ready     consumer accepts when o_valid && i_ready
//   o_timeout   result came from a window with no comparator edge
// ---------------------------------------------------------------------------
module ttd_conv_ctrl #(
    parameter int WIDTH      = 11,
    parameter int RST_CYCLES = 4,
    parameter int OFFSET     = 509,
    parameter int AVG_LOG2   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_cont,
    input  logic       i_cmp_in,
    output logic       o_rst_cap,
    output logic       o_busy,
    output logic [7:0] o_data_out,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_timeout
);

    localparam int DW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISCH,
        S_RAMP,
        S_RESULT,
        S_HOLD
    } state_t;

    state_t             r_state;
    logic               r_sync1, r_sync2, r_sync3;
    logic [WIDTH-1:0]   r_cnt;
    logic [DW-1:0]      r_dcnt;
    logic [WIDTH-1:0]   r_raw;
    logic               r_to;

    logic               w_edge;
    logic [WIDTH-1:0]   w_val;
    logic               w_to_out;
    logic [WIDTH:0]     w_diff;
    logic [7:0]         w_code;

    assign w_edge = r_sync2 & ~r_sync3;

`ifdef TTD_AVG_EN
    logic [WIDTH+AVG_LOG2-1:0] r_acc;
    logic [AVG_LOG2:0]         r_grp;
    logic                      r_to_any;
    logic [WIDTH+AVG_LOG2-1:0] w_sum;
    logic                      w_last;

    // Timeout captures hold raw = 0, so they add nothing to the sum.
    assign w_sum    = r_acc + {{AVG_LOG2{1'b0}}, r_raw};
    assign w_val    = WIDTH'(w_sum >> AVG_LOG2);
    assign w_to_out = r_to_any | r_to;
    assign w_last   = (r_grp == (AVG_LOG2+1)'((1 << AVG_LOG2) - 1));
`else
    assign w_val    = r_raw;
    assign w_to_out = r_to;
`endif

    // raw - OFFSET in WIDTH+1 bits; the top bit is the sign.
    assign w_diff = {1'b0, w_val} - (WIDTH+1)'(OFFSET);

    always_comb begin
        w_code = w_diff[7:0];
        if (w_to_out || w_diff[WIDTH])
            w_code = 8'd0;
        else if (|w_diff[WIDTH-1:8])
            w_code = 8'hFF;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_cnt      <= '1;
            r_dcnt     <= '0;
            r_raw      <= '0;
            r_to       <= 1'b0;
            o_rst_cap  <= 1'b1;
            o_busy     <= 1'b0;
            o_data_out <= 8'd0;
            o_valid    <= 1'b0;
            o_timeout  <= 1'b0;
`ifdef TTD_AVG_EN
            r_acc      <= '0;
            r_grp      <= '0;
            r_to_any   <= 1'b0;
`endif
        end else begin
            r_sync1 <= i_cmp_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_DISCH;
                        r_dcnt  <= '0;
                        o_busy  <= 1'b1;
                    end
                end

                S_DISCH: begin
                    if (r_dcnt == DW'(RST_CYCLES - 1)) begin
                        r_state   <= S_RAMP;
                        r_cnt     <= '1;
                        o_rst_cap <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end

                // An edge in the cycle the counter reaches 0 still counts
                // as a hit: raw = 0 with no timeout.
                S_RAMP: begin
                    if (w_edge || r_cnt == '0) begin
                        r_raw     <= r_cnt;
                        r_to      <= ~w_edge;
                        r_state   <= S_RESULT;
                        o_rst_cap <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_RESULT: begin
`ifdef TTD_AVG_EN
                    r_acc    <= w_sum;
                    r_to_any <= w_to_out;
                    if (w_last) begin
                        o_data_out <= w_code;
                        o_timeout  <= w_to_out;
                        o_valid    <= 1'b1;
                        r_state    <= S_HOLD;
                    end else begin
                        r_grp   <= r_grp + 1'b1;
                        r_dcnt  <= '0;
                        r_state <= S_DISCH;
                    end
`else
                    o_data_out <= w_code;
                    o_timeout  <= r_to;
                    o_valid    <= 1'b1;
                    r_state    <= S_HOLD;
`endif
                end

                S_HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
`ifdef TTD_AVG_EN
                        r_acc    <= '0;
                        r_grp    <= '0;
                        r_to_any <= 1'b0;
`endif
                        if (i_cont) begin
                            r_state <= S_DISCH;
                            r_dcnt  <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ttd_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ttd_conv_ctrl
// Self-checking bench. Each conversion is described by its ramp hit index k
// (or "no edge"); the expected cycle-by-cycle busy/rst_cap/valid and the
// expected result are derived from that description, and a negedge process
// compares the DUT against them every cycle.
// ---------------------------------------------------------------------------
module tb_ttd_conv_ctrl;

    localparam int WIDTH      = 11;
    localparam int RST_CYCLES = 4;
    localparam int OFFSET     = 509;
    localparam int TOP        = (1 << WIDTH) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       cmp = 1'b0;
    logic       ready = 1'b0;
    logic       rst_cap, busy, valid, timeout;
    logic [7:0] data;

    int   n_chk = 0;
    int   n_fail = 0;

    bit         chk_en = 1'b0;
    bit         e_busy = 1'b0;
    bit         e_cap = 1'b1;
    bit         e_valid = 1'b0;
    bit         e_to = 1'b0;
    logic [7:0] e_data = 8'd0;

    ttd_conv_ctrl #(
        .WIDTH(WIDTH), .RST_CYCLES(RST_CYCLES), .OFFSET(OFFSET), .AVG_LOG2(2)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_cont(cont),
        .i_cmp_in(cmp), .o_rst_cap(rst_cap), .o_busy(busy),
        .o_data_out(data), .o_valid(valid), .i_ready(ready),
        .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected 8-bit result for a hit in ramp cycle k (or a timeout).
    function automatic int model_code(input int k, input bit to);
        int c;
        if (to) return 0;
        c = (TOP - k) - OFFSET;
        if (c < 0) return 0;
        if (c > 255) return 255;
        return c;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, e_busy);
            check("rst_cap", rst_cap, e_cap);
            check("valid", valid, e_valid);
            if (e_valid) begin
                check("data_out", data, e_data);
                check("timeout", timeout, e_to);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Async reset mid-cycle, comparator activity during and after reset.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        e_busy = 1'b0; e_cap = 1'b1; e_valid = 1'b0;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_cap", rst_cap, 1);
        check("rst_async_valid", valid, 0);
        start = 1'b0; ready = 1'b0;
        cmp = 1'b1; tick();
        cmp = 1'b0; tick();
        cmp = 1'b1; tick();
        rst_n = 1'b1;
        repeat (8) tick();
        cmp = 1'b0;
        repeat (3) tick();
    endtask

    // One conversion. j counts cycles after the edge that entered DISCH.
    // Timeline: DISCH j=0..3, RAMP j=4..4+K, RESULT j=5+K, HOLD from 6+K.
    task automatic conv(input bit from_idle, input int k, input bit noedge,
                        input int hold, input bit c, input int abort_at,
                        output int lat, output int caplow,
                        output int d0, output int to0);
        int K;
        int last;
        K = noedge ? TOP : k;
        last = 6 + K + hold;
        lat = -1; caplow = 0; d0 = -1; to0 = -1;
        cont = c;
        if (from_idle) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int j = 0; j <= last; j++) begin
            if (j == abort_at) begin
                do_reset();
                return;
            end
            if (!noedge && j == k + 2) cmp = 1'b1;
            start   = (j >= 1 && j <= 5 + K && $urandom_range(0, 7) == 0);
            e_busy  = 1'b1;
            e_cap   = !(j >= 4 && j <= 4 + K);
            e_valid = (j >= 6 + K);
            e_data  = 8'(model_code(k, noedge));
            e_to    = noedge;
            ready   = (j == last);
            if (rst_cap == 1'b0) caplow++;
            if (valid && lat < 0) begin
                lat = j; d0 = int'(data); to0 = int'(timeout);
            end
            tick();
        end
        ready = 1'b0; cmp = 1'b0; start = 1'b0;
        e_valid = 1'b0; e_busy = c; e_cap = 1'b1;
    endtask

    int lat, cl, d0, to0;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_rst_cap", rst_cap, 1);
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_data", data, 0);
        check("reset_timeout", timeout, 0);
        chk_en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();

`ifdef TTD_AVG_EN
        begin
            int nv;
            int kk;
            nv = 0;
            chk_en = 1'b0;
            start = 1'b1; tick(); start = 1'b0;
            for (int g = 0; g < 4; g++) begin
                kk = TOP - (600 + 2 * g);
                for (int j = 0; j < 6 + kk; j++) begin
                    if (j == kk + 2) cmp = 1'b1;
                    if (valid) nv++;
                    tick();
                end
                cmp = 1'b0;
            end
            check("avg_no_early_valid", nv, 0);
            check("avg_valid", valid, 1);
            check("avg_data", data, 94);
            check("avg_timeout", timeout, 0);
            ready = 1'b1; tick(); ready = 1'b0;
            check("avg_valid_clear", valid, 0);
            check("avg_busy_clear", busy, 0);
        end
`else
        // raw 600 -> 91, with latency and rst_cap-low length pinned
        conv(1, 1447, 0, 3, 0, -1, lat, cl, d0, to0);
        check("lat_600", lat, 1453);
        check("caplow_600", cl, 1448);
        check("data_600", d0, 91);
        check("to_600", to0, 0);
        // raw 400 -> 0, raw 1000 -> 255
        conv(1, 1647, 0, 1, 0, -1, lat, cl, d0, to0);
        check("data_400", d0, 0);
        conv(1, 1047, 0, 0, 0, -1, lat, cl, d0, to0);
        check("data_1000", d0, 255);
        // saturation boundaries: raw 764 -> 255, raw 763 -> 254, raw 509 -> 0
        conv(1, 1283, 0, 0, 0, -1, lat, cl, d0, to0);
        check("data_764", d0, 255);
        conv(1, 1284, 0, 0, 0, -1, lat, cl, d0, to0);
        check("data_763", d0, 254);
        conv(1, 1538, 0, 0, 0, -1, lat, cl, d0, to0);
        check("data_509", d0, 0);
        // no edge for the full window
        conv(1, 0, 1, 2, 0, -1, lat, cl, d0, to0);
        check("to_data", d0, 0);
        check("to_flag", to0, 1);
        check("to_caplow", cl, 2048);
        // edge in the same cycle the counter reaches 0
        conv(1, TOP, 0, 0, 0, -1, lat, cl, d0, to0);
        check("last_cycle_edge_to", to0, 0);
        // continuous mode with back-pressure, next DISCH right after handshake
        conv(1, 1447, 0, 20, 1, -1, lat, cl, d0, to0);
        conv(0, 300, 0, 0, 0, -1, lat, cl, d0, to0);
        check("cont_second_data", d0, 255);
        // randomized conversions
        begin
            bit prev_c;
            bit cc;
            int kk;
            prev_c = 1'b0;
            for (int n = 0; n < 10; n++) begin
                kk = $urandom_range(0, 1700);
                cc = (n == 9) ? 1'b0 : 1'(($urandom_range(0, 1)));
                conv(!prev_c, kk, 0, $urandom_range(0, 5), cc, -1, lat, cl, d0, to0);
                prev_c = cc;
            end
        end
        // reset in the middle of a ramp, then a clean conversion
        conv(1, 500, 0, 0, 0, 100, lat, cl, d0, to0);
        conv(1, 1447, 0, 0, 0, -1, lat, cl, d0, to0);
        check("post_reset_data", d0, 91);
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
